// File: rtl/game_flow_ctrl_if.sv
// Purpose: groups the player/key/frame inputs and status outputs of game_flow_ctrl.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is level or single-cycle pulse.
interface game_flow_ctrl_if;
   logic [15:0] keycode_girl;
   logic [15:0] keycode_boy;
   logic        frame_tick;
   logic        girl_at_door;
   logic        boy_at_door;
   logic        girl_dead;
   logic        boy_dead;
   logic [1:0]  game_state;
   logic        run_en;
   logic        restart;
   logic [9:0]  time_sec;

   // Drives the game inputs and observes the flow status.
   modport master (
      output keycode_girl, keycode_boy, frame_tick,
      output girl_at_door, boy_at_door, girl_dead, boy_dead,
      input  game_state, run_en, restart, time_sec
   );

   // The flow controller itself.
   modport slave (
      input  keycode_girl, keycode_boy, frame_tick,
      input  girl_at_door, boy_at_door, girl_dead, boy_dead,
      output game_state, run_en, restart, time_sec
   );
endinterface

// File: rtl/game_flow_ctrl.sv
// Purpose: game flow FSM (TITLE/PLAY/WIN/OVER) with play timer, win hold and end-screen wait.
// Latency: one Clk from key edge / frame event to registered state and outputs.
// Backpressure: none; inputs are sampled every cycle, keys act on rising edge only.
module game_flow_ctrl #(
   parameter int FRAMES_PER_SEC = 60,
   parameter int TIME_MAX       = 999,
   parameter int WIN_HOLD       = 30,
   parameter int END_WAIT       = 60
) (
   input logic             Clk,
   input logic             Reset,
   game_flow_ctrl_if.slave bus
);

   localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam int WW = $clog2(WIN_HOLD + 1);
   localparam int EW = $clog2(END_WAIT + 1);

   typedef enum logic [1:0] {
      TITLE = 2'd0,
      PLAY  = 2'd1,
      WIN   = 2'd2,
      OVER  = 2'd3
   } state_t;

   state_t        state;
   logic          any_key;
   logic          any_key_q;
   logic          key_armed;
   logic          key_rise;
   logic          death;
   logic          both_door;
   logic          sec_wrap;
   logic          time_out;
   logic          win_hit;
   logic [FW-1:0] frame_cnt;
   logic [WW-1:0] win_cnt;
   logic [EW-1:0] end_cnt;
   logic [9:0]    time_sec_q;
   logic          run_en_q;
   logic          restart_q;

   assign any_key   = (bus.keycode_girl != 16'd0) || (bus.keycode_boy != 16'd0);
   // key_armed blocks a key that was already held when Reset released.
   assign key_rise  = any_key && !any_key_q && key_armed;
   assign death     = bus.girl_dead || bus.boy_dead;
   assign both_door = bus.girl_at_door && bus.boy_at_door;
   assign sec_wrap  = bus.frame_tick && (frame_cnt == FW'(FRAMES_PER_SEC - 1));
   assign time_out  = sec_wrap && ((time_sec_q + 10'd1) == 10'(TIME_MAX));
   assign win_hit   = bus.frame_tick && both_door && (win_cnt == WW'(WIN_HOLD - 1));

   // Key history for edge detection; arm only once all keys have been seen released.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         any_key_q <= 1'b0;
         key_armed <= 1'b0;
      end else begin
         any_key_q <= any_key;
         if (!any_key)
            key_armed <= 1'b1;
      end
   end

   // Flow FSM with its counters and registered outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= TITLE;
         run_en_q   <= 1'b0;
         restart_q  <= 1'b0;
         frame_cnt  <= '0;
         win_cnt    <= '0;
         end_cnt    <= '0;
         time_sec_q <= '0;
      end else begin
         restart_q <= 1'b0;
         case (state)
            TITLE: begin
               if (key_rise) begin
                  state      <= PLAY;
                  run_en_q   <= 1'b1;
                  restart_q  <= 1'b1;
                  frame_cnt  <= '0;
                  win_cnt    <= '0;
                  end_cnt    <= '0;
                  time_sec_q <= '0;
               end
            end
            PLAY: begin
               if (death) begin
                  // A death freezes everything, including a tick arriving the same cycle.
                  state    <= OVER;
                  run_en_q <= 1'b0;
                  end_cnt  <= '0;
               end else begin
                  if (bus.frame_tick) begin
                     frame_cnt <= sec_wrap ? '0 : frame_cnt + FW'(1);
                     win_cnt   <= both_door ? win_cnt + WW'(1) : '0;
                     if (sec_wrap && (time_sec_q != 10'(TIME_MAX)))
                        time_sec_q <= time_sec_q + 10'd1;
                  end
                  if (time_out || win_hit) begin
                     state    <= time_out ? OVER : WIN;
                     run_en_q <= 1'b0;
                     end_cnt  <= '0;
                  end
               end
            end
            WIN, OVER: begin
               if (bus.frame_tick && (end_cnt != EW'(END_WAIT)))
                  end_cnt <= end_cnt + EW'(1);
               if (key_rise && (end_cnt == EW'(END_WAIT)))
                  state <= TITLE;
            end
            default: begin
               state    <= TITLE;
               run_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.game_state = state;
   assign bus.run_en     = run_en_q;
   assign bus.restart    = restart_q;
   assign bus.time_sec   = time_sec_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Purpose: directed bench for game_flow_ctrl, default and short-timer instances side by side.
// Latency: outputs compared 1 time unit after every rising Clk against a frame-level model.
// Backpressure: none; stimulus is applied between clock edges.
module tb_game_flow_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] key_g = '0;
   logic [15:0] key_b = '0;
   logic        tick = 1'b0;
   logic        gdoor = 1'b0;
   logic        bdoor = 1'b0;
   logic        gdead = 1'b0;
   logic        bdead = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   always #5 Clk = ~Clk;

   game_flow_ctrl_if ifa ();
   game_flow_ctrl_if ifb ();

   assign ifa.keycode_girl = key_g;
   assign ifa.keycode_boy  = key_b;
   assign ifa.frame_tick   = tick;
   assign ifa.girl_at_door = gdoor;
   assign ifa.boy_at_door  = bdoor;
   assign ifa.girl_dead    = gdead;
   assign ifa.boy_dead     = bdead;
   assign ifb.keycode_girl = key_g;
   assign ifb.keycode_boy  = key_b;
   assign ifb.frame_tick   = tick;
   assign ifb.girl_at_door = gdoor;
   assign ifb.boy_at_door  = bdoor;
   assign ifb.girl_dead    = gdead;
   assign ifb.boy_dead     = bdead;

   game_flow_ctrl dut_a (.Clk(Clk), .Reset(Reset), .bus(ifa));
   game_flow_ctrl #(.FRAMES_PER_SEC(2), .TIME_MAX(3)) dut_b (.Clk(Clk), .Reset(Reset), .bus(ifb));

   // Frame-level view of the game: total play frames, current door streak, frames since the end.
   typedef struct {
      int mode;
      bit prev_key;
      bit armed;
      int ticks;
      int door_run;
      int end_frames;
      bit restart;
      int tsec;
   } model_t;

   model_t ma = '{default: 0};
   model_t mb = '{default: 0};

   function automatic model_t step(model_t m, bit rst, bit key, bit tk, bit both, bit dead,
                                   int fps, int tmax, int whold, int ewait);
      bit kr;
      if (rst) begin
         m = '{default: 0};
         return m;
      end
      kr = key && !m.prev_key && m.armed;
      m.prev_key = key;
      if (!key) m.armed = 1;
      m.restart = 0;
      case (m.mode)
         0: if (kr) begin
            m.mode = 1; m.restart = 1; m.ticks = 0; m.door_run = 0; m.tsec = 0;
         end
         1: begin
            if (dead) begin
               m.mode = 3; m.end_frames = 0;
            end else if (tk) begin
               m.ticks++;
               m.door_run = both ? m.door_run + 1 : 0;
               m.tsec = (m.ticks / fps < tmax) ? m.ticks / fps : tmax;
               if (m.tsec == tmax) begin
                  m.mode = 3; m.end_frames = 0;
               end else if (m.door_run >= whold) begin
                  m.mode = 2; m.end_frames = 0;
               end
            end
         end
         default: begin
            if (kr && m.end_frames == ewait) m.mode = 0;
            else if (tk && m.end_frames < ewait) m.end_frames++;
         end
      endcase
      return m;
   endfunction

   task automatic chk(string name, logic [31:0] got, int exp);
      vectors++;
      if (got !== 32'(exp)) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
      end
   endtask

   // One clock: advance both models on the edge, then compare every output of both DUTs.
   task automatic cycle();
      bit key;
      @(posedge Clk);
      key = (key_g != 0) || (key_b != 0);
      ma = step(ma, Reset, key, tick, gdoor && bdoor, gdead || bdead, 60, 999, 30, 60);
      mb = step(mb, Reset, key, tick, gdoor && bdoor, gdead || bdead, 2, 3, 30, 60);
      #1;
      chk("A.game_state", 32'(ifa.game_state), ma.mode);
      chk("A.run_en",     32'(ifa.run_en),     int'(ma.mode == 1));
      chk("A.restart",    32'(ifa.restart),    int'(ma.restart));
      chk("A.time_sec",   32'(ifa.time_sec),   ma.tsec);
      chk("B.game_state", 32'(ifb.game_state), mb.mode);
      chk("B.run_en",     32'(ifb.run_en),     int'(mb.mode == 1));
      chk("B.restart",    32'(ifb.restart),    int'(mb.restart));
      chk("B.time_sec",   32'(ifb.time_sec),   mb.tsec);
   endtask

   task automatic do_ticks(int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1; cycle();
         tick = 1'b0; cycle();
      end
   endtask

   task automatic press(logic [15:0] g, logic [15:0] b);
      key_g = g; key_b = b; cycle();
      key_g = '0; key_b = '0; cycle();
   endtask

   initial begin
      int rst_cnt;

      // Reset with a key held; holding it past release must not start play.
      key_g = 16'h0004;
      repeat (3) cycle();
      chk("reset A.state", 32'(ifa.game_state), 0);
      chk("reset A.time", 32'(ifa.time_sec), 0);
      Reset = 1'b0;
      repeat (5) cycle();
      chk("held-through-reset A.state", 32'(ifa.game_state), 0);
      key_g = '0;
      cycle(); cycle();

      // Fresh press starts play with one restart pulse; held key adds no more.
      key_g = 16'h0004;
      cycle();
      chk("start A.state", 32'(ifa.game_state), 1);
      chk("start A.restart", 32'(ifa.restart), 1);
      rst_cnt = int'(ifa.restart);
      for (int i = 0; i < 499; i++) begin
         cycle();
         rst_cnt += int'(ifa.restart);
      end
      chk("restart pulses", 32'(rst_cnt), 1);
      chk("held key A.state", 32'(ifa.game_state), 1);
      key_g = '0;
      cycle();

      // Short timer times out after 6 ticks.
      do_ticks(6);
      chk("timeout B.time", 32'(ifb.time_sec), 3);
      chk("timeout B.state", 32'(ifb.game_state), 3);
      chk("6 ticks A.time", 32'(ifa.time_sec), 0);

      // Early press on the end screen is ignored.
      do_ticks(10);
      press(16'h0004, 16'h0000);
      chk("early press B.state", 32'(ifb.game_state), 3);

      // 120 ticks in total -> two seconds.
      do_ticks(104);
      chk("120 ticks A.time", 32'(ifa.time_sec), 2);
      chk("120 ticks A.state", 32'(ifa.game_state), 1);
      chk("model pin A.tsec", 32'(ma.tsec), 2);

      // Late press returns B to TITLE with the timer frozen.
      press(16'h0000, 16'h0010);
      chk("late press B.state", 32'(ifb.game_state), 0);
      chk("late press B.time", 32'(ifb.time_sec), 3);
      chk("key ignored in PLAY A.state", 32'(ifa.game_state), 1);

      // Door streak broken at 29, then a full 30-tick run wins.
      gdoor = 1'b1; bdoor = 1'b1; do_ticks(29);
      gdoor = 1'b0; bdoor = 1'b0; do_ticks(1);
      gdoor = 1'b1; bdoor = 1'b1; do_ticks(29);
      chk("29 of 30 A.state", 32'(ifa.game_state), 1);
      do_ticks(1);
      chk("win A.state", 32'(ifa.game_state), 2);
      chk("win A.time", 32'(ifa.time_sec), 3);
      chk("win A.run_en", 32'(ifa.run_en), 0);
      chk("model pin A.mode", 32'(ma.mode), 2);
      gdoor = 1'b0; bdoor = 1'b0;

      // WIN: early press ignored, press after the end wait returns to TITLE.
      do_ticks(10);
      press(16'h0004, 16'h0000);
      chk("early press A.state", 32'(ifa.game_state), 2);
      do_ticks(50);
      press(16'h0004, 16'h0000);
      chk("exit A.state", 32'(ifa.game_state), 0);
      chk("exit A.time", 32'(ifa.time_sec), 3);

      // Death on the same tick that would complete the win -> OVER.
      press(16'h0004, 16'h0000);
      chk("replay A.state", 32'(ifa.game_state), 1);
      chk("replay A.time", 32'(ifa.time_sec), 0);
      gdoor = 1'b1; bdoor = 1'b1; do_ticks(29);
      chk("win_cnt 29 A.state", 32'(ifa.game_state), 1);
      bdead = 1'b1; tick = 1'b1; cycle();
      bdead = 1'b0; tick = 1'b0; gdoor = 1'b0; bdoor = 1'b0; cycle();
      chk("death beats win A.state", 32'(ifa.game_state), 3);

      // Reset during play aborts to TITLE without a restart pulse.
      do_ticks(60);
      press(16'h0004, 16'h0000);
      press(16'h0004, 16'h0000);
      chk("play again A.run_en", 32'(ifa.run_en), 1);
      do_ticks(5);
      Reset = 1'b1; cycle();
      chk("mid-play reset A.state", 32'(ifa.game_state), 0);
      chk("mid-play reset A.restart", 32'(ifa.restart), 0);
      chk("mid-play reset A.time", 32'(ifa.time_sec), 0);
      Reset = 1'b0; cycle(); cycle();

      // Girl death ends play.
      press(16'h0004, 16'h0000);
      chk("post-reset start A.state", 32'(ifa.game_state), 1);
      gdead = 1'b1; cycle();
      gdead = 1'b0; cycle();
      chk("girl death A.state", 32'(ifa.game_state), 3);
      chk("girl death A.run_en", 32'(ifa.run_en), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
